// File: rtl/bits_pkg.sv
// Shared definitions for the BITS literal stream decoder.
// Contents: group/nibble geometry, FSM state enum, group payload struct.
package bits_pkg;

  localparam int unsigned GROUP_W  = 5;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned CONT_BIT = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic                cont;
    logic [NIBBLE_W-1:0] nibble;
  } bits_group_t;

endpackage : bits_pkg

// File: rtl/literal_stream_decoder.sv
// Streaming BITS literal decoder: accumulates 4-bit nibbles MSB-first from
// 5-bit groups (bit 4 = continue) and presents the literal on a valid/ready port.
// Ports:
//   clk, resetB                 clock, synchronous active-low reset
//   group_valid/group/group_ready   upstream group handshake
//   number_valid/number_ready   downstream result handshake
//   number, overflow, group_count   result payload
//   bits_consumed               5 x groups accepted (only with LITERAL_BITCOUNT_EN)
// Optional feature macro: LITERAL_BITCOUNT_EN.
module literal_stream_decoder
  import bits_pkg::*;
#(
  parameter int unsigned NUM_W      = 64,
  parameter int unsigned MAX_GROUPS = 16,
  localparam int unsigned CNT_W     = $clog2(MAX_GROUPS + 1)
`ifdef LITERAL_BITCOUNT_EN
  ,
  localparam int unsigned BC_W      = $clog2(5 * MAX_GROUPS + 6)
`endif
) (
  input  logic               clk,
  input  logic               resetB,
  input  logic               group_valid,
  input  logic [GROUP_W-1:0] group,
  output logic               group_ready,
  output logic               number_valid,
  output logic [NUM_W-1:0]   number,
  input  logic               number_ready,
  output logic               overflow,
  output logic [CNT_W-1:0]   group_count
`ifdef LITERAL_BITCOUNT_EN
  ,
  output logic [BC_W-1:0]    bits_consumed
`endif
);

  bits_group_t      grp;
  state_t           state, state_n;
  logic [NUM_W-1:0] acc, acc_n, base_acc;
  logic [CNT_W-1:0] cnt, cnt_n, base_cnt;
  logic             ovf, ovf_n, base_ovf;
  logic             ready, accept, handshake;

`ifdef LITERAL_BITCOUNT_EN
  // Largest multiple of 5 representable; drain can run arbitrarily long.
  localparam int unsigned BC_MAX = (((1 << BC_W) - 1) / 5) * 5;
  logic [BC_W-1:0] bits, bits_n, base_bits;
`endif

  assign grp = bits_group_t'(group);

  // Next-state and accumulator update
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    ready     = (state != DONE) || number_ready;
    accept    = group_valid && ready;
    handshake = (state == DONE) && number_ready;
    base_acc  = acc;
    base_cnt  = cnt;
    base_ovf  = ovf;
`ifdef LITERAL_BITCOUNT_EN
    bits_n    = bits;
    base_bits = bits;
`endif

    // Result taken: start from a clean literal (possibly this same cycle)
    if (handshake) begin
      base_acc = '0;
      base_cnt = '0;
      base_ovf = 1'b0;
      acc_n    = '0;
      cnt_n    = '0;
      ovf_n    = 1'b0;
      state_n  = ACCUM;
`ifdef LITERAL_BITCOUNT_EN
      base_bits = '0;
      bits_n    = '0;
`endif
    end

    if (accept) begin
`ifdef LITERAL_BITCOUNT_EN
      if (32'(base_bits) + 32'd5 > BC_MAX) bits_n = BC_W'(BC_MAX);
      else                                 bits_n = base_bits + BC_W'(5);
`endif
      if (state == DRAIN) begin
        // Groups past the limit are swallowed until the literal terminates
        if (!grp.cont) state_n = DONE;
      end else begin
        acc_n = NUM_W'({base_acc, grp.nibble});
        cnt_n = base_cnt + CNT_W'(1);
        ovf_n = base_ovf || (base_acc[NUM_W-1 -: NIBBLE_W] != '0);
        if (!grp.cont) begin
          state_n = DONE;
        end else if (base_cnt + CNT_W'(1) == CNT_W'(MAX_GROUPS)) begin
          ovf_n   = 1'b1;
          state_n = DRAIN;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetB) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
`ifdef LITERAL_BITCOUNT_EN
      bits  <= '0;
`endif
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
`ifdef LITERAL_BITCOUNT_EN
      bits  <= bits_n;
`endif
    end
  end

  assign group_ready  = ready;
  assign number_valid = (state == DONE);
  assign number       = acc;
  assign overflow     = ovf;
  assign group_count  = cnt;
`ifdef LITERAL_BITCOUNT_EN
  assign bits_consumed = bits;
`endif

endmodule : literal_stream_decoder

// File: tb/tb_literal_stream_decoder.sv
// Testbench for literal_stream_decoder: two instances (64-bit/16 groups and
// 8-bit/4 groups) share one input stream and are checked against a model.
module tb_literal_stream_decoder;

  logic        clk = 1'b0;
  logic        resetB;
  logic        group_valid;
  logic [4:0]  group;
  logic        number_ready;

  logic        ready_a, valid_a, ovf_a;
  logic [63:0] num_a;
  logic [4:0]  cnt_a;
  logic        ready_b, valid_b, ovf_b;
  logic [7:0]  num_b;
  logic [2:0]  cnt_b;
`ifdef LITERAL_BITCOUNT_EN
  logic [6:0]  bits_a;
  logic [4:0]  bits_b;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  literal_stream_decoder #(.NUM_W(64), .MAX_GROUPS(16)) u_a (
    .clk(clk), .resetB(resetB), .group_valid(group_valid), .group(group),
    .group_ready(ready_a), .number_valid(valid_a), .number(num_a),
    .number_ready(number_ready), .overflow(ovf_a), .group_count(cnt_a)
`ifdef LITERAL_BITCOUNT_EN
    , .bits_consumed(bits_a)
`endif
  );

  literal_stream_decoder #(.NUM_W(8), .MAX_GROUPS(4)) u_b (
    .clk(clk), .resetB(resetB), .group_valid(group_valid), .group(group),
    .group_ready(ready_b), .number_valid(valid_b), .number(num_b),
    .number_ready(number_ready), .overflow(ovf_b), .group_count(cnt_b)
`ifdef LITERAL_BITCOUNT_EN
    , .bits_consumed(bits_b)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] na; int ca; logic oa;
    logic [7:0]  nb; int cb; logic ob;
    int ba; int bb;
  } res_t;

  res_t       expq[$];
  logic [3:0] lit[$];

  // Literal value = concatenation of the first min(len, mg) nibbles; overflow if
  // the limit was exceeded or the full value does not fit in nw bits.
  function automatic void model(input logic [3:0] nibs[$], input int nw, input int mg,
                                output logic [127:0] num, output int cnt, output logic ovf);
    logic [127:0] val;
    int n;
    val = '0;
    n   = (nibs.size() < mg) ? nibs.size() : mg;
    for (int i = 0; i < n; i++) val = (val << 4) | 128'(nibs[i]);
    ovf = (nibs.size() > mg) || ((val >> nw) != 0);
    num = val & ((128'd1 << nw) - 128'd1);
    cnt = n;
  endfunction

  function automatic int bits_exp(input int len, input int w);
    int mx;
    mx = (((1 << w) - 1) / 5) * 5;
    return (5 * len > mx) ? mx : 5 * len;
  endfunction

  // Monitor: checks handshake signals and held results every cycle
  always @(negedge clk) begin
    if (!resetB) begin
      lit.delete();
      expq.delete();
    end else begin
      logic         pend, exp_ready;
      logic [127:0] n;
      int           c;
      logic         o;
      res_t         r;
      pend      = (expq.size() != 0);
      exp_ready = !pend || number_ready;
      check("valid_a", valid_a, pend);
      check("valid_b", valid_b, pend);
      check("ready_a", ready_a, exp_ready);
      check("ready_b", ready_b, exp_ready);
      if (pend) begin
        r = expq[0];
        check("num_a", num_a, r.na);
        check("cnt_a", cnt_a, r.ca);
        check("ovf_a", ovf_a, r.oa);
        check("num_b", num_b, r.nb);
        check("cnt_b", cnt_b, r.cb);
        check("ovf_b", ovf_b, r.ob);
`ifdef LITERAL_BITCOUNT_EN
        check("bits_a", bits_a, r.ba);
        check("bits_b", bits_b, r.bb);
`endif
        if (number_ready) void'(expq.pop_front());
      end
      if (group_valid && exp_ready) begin
        lit.push_back(group[3:0]);
        if (!group[4]) begin
          model(lit, 64, 16, n, c, o);
          r.na = n[63:0]; r.ca = c; r.oa = o;
          model(lit, 8, 4, n, c, o);
          r.nb = n[7:0];  r.cb = c; r.ob = o;
          r.ba = bits_exp(lit.size(), 7);
          r.bb = bits_exp(lit.size(), 5);
          expq.push_back(r);
          lit.delete();
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]  g[8];
    int          len;
    logic [63:0] na; int ca; logic oa;
    logic [7:0]  nb; int cb; logic ob;
    int          bits;
  } vec_t;

  vec_t vt[5];

  task automatic send(input logic [4:0] g);
    bit done;
    done        = 1'b0;
    group_valid = 1'b1;
    group       = g;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (ready_a) done = 1'b1;
      @(posedge clk); #1;
    end
    group_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: group 0x%0h never accepted", g);
    end
  endtask

  task automatic take();
    number_ready = 1'b1;
    @(posedge clk); #1;
    number_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0].g = '{5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    vt[0].len = 1; vt[0].na = 64'h5;   vt[0].ca = 1; vt[0].oa = 0;
    vt[0].nb = 8'h05; vt[0].cb = 1; vt[0].ob = 0; vt[0].bits = 5;
    vt[1].g = '{5'b10111, 5'b11110, 5'b00101, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    vt[1].len = 3; vt[1].na = 64'h7E5; vt[1].ca = 3; vt[1].oa = 0;
    vt[1].nb = 8'hE5; vt[1].cb = 3; vt[1].ob = 1; vt[1].bits = 15;
    vt[2].g = '{5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b00001, 5'd0, 5'd0};
    vt[2].len = 6; vt[2].na = 64'h9ABCD1; vt[2].ca = 6; vt[2].oa = 0;
    vt[2].nb = 8'hBC; vt[2].cb = 4; vt[2].ob = 1; vt[2].bits = 30;
    vt[3].g = '{5'b10001, 5'b10010, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    vt[3].len = 3; vt[3].na = 64'h123; vt[3].ca = 3; vt[3].oa = 0;
    vt[3].nb = 8'h23; vt[3].cb = 3; vt[3].ob = 1; vt[3].bits = 15;
    vt[4].g = '{5'b10000, 5'b10000, 5'b10001, 5'b00010, 5'd0, 5'd0, 5'd0, 5'd0};
    vt[4].len = 4; vt[4].na = 64'h12; vt[4].ca = 4; vt[4].oa = 0;
    vt[4].nb = 8'h12; vt[4].cb = 4; vt[4].ob = 0; vt[4].bits = 20;

    resetB = 1'b0; group_valid = 1'b0; group = '0; number_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_num_a", num_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_valid_b", valid_b, 0);
    @(posedge clk); #1;
    resetB = 1'b1;

    // Table: results held with number_ready low, then taken
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vt[v].len; j++) send(vt[v].g[j]);
      @(negedge clk);
      check("tbl_valid", valid_a, 1);
      check("tbl_num_a", num_a, vt[v].na);
      check("tbl_cnt_a", cnt_a, vt[v].ca);
      check("tbl_ovf_a", ovf_a, vt[v].oa);
      check("tbl_num_b", num_b, vt[v].nb);
      check("tbl_cnt_b", cnt_b, vt[v].cb);
      check("tbl_ovf_b", ovf_b, vt[v].ob);
`ifdef LITERAL_BITCOUNT_EN
      check("tbl_bits_a", bits_a, vt[v].bits);
      check("tbl_bits_b", bits_b, vt[v].bits);
`endif
      @(posedge clk); #1;
      take();
    end

    // Backpressure with a waiting group, then same-cycle handshake + accept
    send(5'b00011);
    group_valid = 1'b1; group = 5'b00111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", ready_a, 0);
      check("bp_num", num_a, 3);
      check("bp_valid", valid_a, 1);
      @(posedge clk); #1;
    end
    number_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_release", ready_a, 1);
    @(posedge clk); #1;
    number_ready = 1'b0; group_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", valid_a, 1);
    check("bp_next_num_a", num_a, 7);
    check("bp_next_cnt_a", cnt_a, 1);
    check("bp_next_num_b", num_b, 7);
    @(posedge clk); #1;
    take();

    // Reset in the middle of a literal
    send(5'b11001);
    send(5'b11010);
    resetB = 1'b0;
    @(posedge clk); #1;
    resetB = 1'b1;
    @(negedge clk);
    check("mid_rst_num", num_a, 0);
    check("mid_rst_cnt", cnt_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    check("mid_rst_valid", valid_a, 0);
    @(posedge clk); #1;
    send(5'b00001);
    @(negedge clk);
    check("post_rst_num", num_a, 1);
    check("post_rst_cnt", cnt_a, 1);
    @(posedge clk); #1;
    take();

    // Random traffic; alternating windows favour long literals (limit/drain)
    for (int i = 0; i < 4000; i++) begin
      int cp;
      cp           = ((i / 300) % 2 == 1) ? 19 : 14;
      group_valid  = ($urandom_range(0, 3) != 0);
      group        = {($urandom_range(0, 19) < cp) ? 1'b1 : 1'b0, 4'($urandom)};
      number_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    number_ready = 1'b1;
    send(5'b00000);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("final_idle", valid_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_literal_stream_decoder
